// File: rtl/pixel_seq_ctrl_if.sv
// Row readout stream between pixel_seq_ctrl (master) and its consumer (slave).
interface pixel_seq_ctrl_if #(
  parameter int DW = 16
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (output out_valid, output out_data, output out_last, input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_last, output out_ready);
endinterface

// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer for a ROWS x COLS pixel array: ERASE -> EXPOSE -> CONVERT -> READ -> DONE.
// Optional SEQ_FRAME_COUNT_EN adds frame_cnt and a header beat ahead of row 0.
module pixel_seq_ctrl #(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int ADC_BITS     = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_BITS     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [EXP_BITS-1:0]      expose_len,
  output logic                     erase,
  output logic                     expose,
  output logic                     convert,
  output logic [ADC_BITS-1:0]      adc_code,
  input  logic [COLS*ADC_BITS-1:0] pix_data,
  output logic [$clog2(ROWS):0]    row_sel,
  pixel_seq_ctrl_if.master         rd,
  output logic                     frame_done,
`ifdef SEQ_FRAME_COUNT_EN
  output logic [15:0]              frame_cnt,
`endif
  output logic                     busy
);
  localparam int          DW       = COLS*ADC_BITS;
  localparam int          RW       = $clog2(ROWS)+1;
  localparam logic [31:0] CVT_LAST = (32'd1 << ADC_BITS) - 32'd1;
  localparam logic [31:0] ERS_LAST = 32'(ERASE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, DONE} state_t;

  state_t               state, state_nx;
  logic [31:0]          cnt;
  logic [31:0]          exp_last;
  logic [EXP_BITS-1:0]  exp_len;
  logic                 hdr;
  logic                 rd_acc;
  logic                 cvt_end;
  logic [DW-1:0]        hdr_word;

`ifdef SEQ_FRAME_COUNT_EN
  localparam bit HDR_EN = 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset)             frame_cnt <= '0;
    else if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
  assign hdr_word = DW'(frame_cnt[7:0]);
`else
  localparam bit HDR_EN = 1'b0;
  assign hdr_word = '0;
`endif

  // A zero exposure still spends one cycle in EXPOSE.
  assign exp_last = (exp_len == '0) ? 32'd0 : 32'(exp_len) - 32'd1;
  assign rd_acc   = rd.out_valid && rd.out_ready;
  assign cvt_end  = (state == CONVERT) && (cnt == CVT_LAST);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)                       state_nx = ERASE;
      ERASE:   if (cnt == ERS_LAST)             state_nx = EXPOSE;
      EXPOSE:  if (cnt == exp_last)             state_nx = CONVERT;
      CONVERT: if (cnt == CVT_LAST)             state_nx = READ;
      READ:    if (rd_acc && rd.out_last)       state_nx = DONE;
      DONE:    state_nx = continuous ? ERASE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset)                                           cnt <= '0;
    else if (state_nx != state)                           cnt <= '0;
    else if (state inside {ERASE, EXPOSE, CONVERT})       cnt <= cnt + 32'd1;

  always_ff @(posedge clk or negedge reset)
    if (!reset)                                                    exp_len <= '0;
    else if ((state == IDLE && start) || (state == DONE && continuous)) exp_len <= expose_len;

  // The first beat is loaded on the last ramp edge so READ+DONE costs 2*ROWS cycles.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row_sel      <= '0;
      hdr          <= 1'b0;
      rd.out_valid <= 1'b0;
      rd.out_data  <= '0;
      rd.out_last  <= 1'b0;
    end else if (cvt_end) begin
      row_sel      <= '0;
      hdr          <= HDR_EN;
      rd.out_valid <= 1'b1;
      rd.out_data  <= HDR_EN ? hdr_word : pix_data;
      rd.out_last  <= !HDR_EN && (ROWS == 1);
    end else if (state == READ) begin
      if (rd_acc) begin
        rd.out_valid <= 1'b0;
        rd.out_last  <= 1'b0;
        if (hdr)              hdr     <= 1'b0;
        else if (rd.out_last) row_sel <= '0;
        else                  row_sel <= row_sel + RW'(1);
      end else if (!rd.out_valid) begin
        rd.out_valid <= 1'b1;
        rd.out_data  <= pix_data;
        rd.out_last  <= (row_sel == RW'(ROWS-1));
      end
    end

  assign erase      = (state == ERASE);
  assign expose     = (state == EXPOSE);
  assign convert    = (state == CONVERT);
  assign adc_code   = convert ? cnt[ADC_BITS-1:0] : '0;
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Directed bench for pixel_seq_ctrl (ROWS=2, COLS=2, ADC_BITS=8).
module tb_pixel_seq_ctrl;
  localparam int DW = 16;
`ifdef SEQ_FRAME_COUNT_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int E10 = 10;
  localparam int PER = 5 + E10 + 256 + 4 + 2*HDR;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, continuous = 1'b0, out_ready = 1'b0;
  logic [15:0] expose_len = '0;
  logic        erase, expose, convert, frame_done, busy;
  logic [7:0]  adc_code;
  logic [15:0] pix_data;
  logic [1:0]  row_sel;
`ifdef SEQ_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0, errors = 0;
  int n_erase, n_expose, n_convert, adc_bad, n_fd, busy_low, cyc;
  logic [15:0] bdata[$];
  logic        blast[$];
  int          t_fd[$];

  pixel_seq_ctrl_if #(.DW(DW)) rd();
  assign rd.out_ready = out_ready;
  assign pix_data = (row_sel == 2'd0) ? 16'h1122 : 16'h3344;

  always #5 clk = ~clk;

  pixel_seq_ctrl #(.ROWS(2), .COLS(2), .ADC_BITS(8), .ERASE_CYCLES(5), .EXP_BITS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .expose_len(expose_len),
    .erase(erase), .expose(expose), .convert(convert), .adc_code(adc_code), .pix_data(pix_data),
    .row_sel(row_sel), .rd(rd), .frame_done(frame_done),
`ifdef SEQ_FRAME_COUNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy));

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Per-cycle observer; optionally pulses start mid-EXPOSE.
  task automatic mon(input int nfr, input int maxc, input bit poke);
    n_erase = 0; n_expose = 0; n_convert = 0; adc_bad = 0; n_fd = 0; busy_low = 0; cyc = 0;
    bdata.delete(); blast.delete(); t_fd.delete();
    while (n_fd < nfr && cyc < maxc) begin
      @(negedge clk); cyc++;
      if (erase)  n_erase++;
      if (expose) n_expose++;
      if (convert) begin
        if (adc_code !== n_convert[7:0]) adc_bad++;
        n_convert++;
      end
      if (!busy) busy_low++;
      if (rd.out_valid && out_ready) begin bdata.push_back(rd.out_data); blast.push_back(rd.out_last); end
      if (frame_done) begin n_fd++; t_fd.push_back(cyc); end
      start = poke && expose && (n_expose == 3);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    checks++; if ({erase, expose, convert, adc_code, frame_done, busy} !== '0) begin errors++; $display("FAIL rst_phase: got %0h expected 0", {erase, expose, convert, adc_code, frame_done, busy}); end
    checks++; if ({rd.out_valid, rd.out_data, rd.out_last, row_sel} !== '0) begin errors++; $display("FAIL rst_bus: got %0h expected 0", {rd.out_valid, rd.out_data, rd.out_last, row_sel}); end
    reset = 1'b1;
    expose_len = 16'd4; out_ready = 1'b1;
    kick();
    n = 0;
    while (adc_code !== 8'd37 && n < 400) begin @(negedge clk); n++; end
    checks++; if (adc_code !== 8'd37) begin errors++; $display("FAIL rst_reach37: got %0d expected 37", adc_code); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({convert, adc_code, busy, frame_done} !== '0) begin errors++; $display("FAIL rst_async: got %0h expected 0", {convert, adc_code, busy, frame_done}); end
    checks++; if ({rd.out_valid, row_sel, rd.out_last} !== '0) begin errors++; $display("FAIL rst_async_bus: got %0h expected 0", {rd.out_valid, row_sel, rd.out_last}); end
    @(negedge clk); reset = 1'b1;
    mon(1, 20, 1'b0);
    checks++; if (n_fd != 0 || busy_low != 20) begin errors++; $display("FAIL rst_idle: got fd=%0d idle=%0d expected fd=0 idle=20", n_fd, busy_low); end
  endtask

  task automatic test_single_frame();
    expose_len = E10; out_ready = 1'b1; continuous = 1'b0;
    kick();
    mon(1, 600, 1'b0);
    checks++; if (n_erase != 5)    begin errors++; $display("FAIL sf_erase: got %0d expected 5", n_erase); end
    checks++; if (n_expose != 10)  begin errors++; $display("FAIL sf_expose: got %0d expected 10", n_expose); end
    checks++; if (n_convert != 256) begin errors++; $display("FAIL sf_convert: got %0d expected 256", n_convert); end
    checks++; if (adc_bad != 0)    begin errors++; $display("FAIL sf_ramp: got %0d bad codes expected 0", adc_bad); end
    checks++; if (bdata.size() != 2+HDR) begin errors++; $display("FAIL sf_beats: got %0d expected %0d", bdata.size(), 2+HDR); end
    if (bdata.size() == 2+HDR) begin
      checks++; if (bdata[HDR] !== 16'h1122 || blast[HDR] !== 1'b0) begin errors++; $display("FAIL sf_row0: got %0h/%0b expected 1122/0", bdata[HDR], blast[HDR]); end
      checks++; if (bdata[HDR+1] !== 16'h3344 || blast[HDR+1] !== 1'b1) begin errors++; $display("FAIL sf_row1: got %0h/%0b expected 3344/1", bdata[HDR+1], blast[HDR+1]); end
    end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL sf_done: got %0d expected 1", n_fd); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sf_after: got fd=%0b busy=%0b expected 0/0", frame_done, busy); end
  endtask

  task automatic test_exposure_edge();
    expose_len = 16'd0;
    kick();
    mon(1, 600, 1'b0);
    checks++; if (n_expose != 1 || n_convert != 256) begin errors++; $display("FAIL exp_zero: got exp=%0d cvt=%0d expected 1/256", n_expose, n_convert); end
    expose_len = E10;
    kick();
    mon(1, 600, 1'b1);
    checks++; if (n_erase != 5 || n_expose != 10 || n_fd != 1) begin errors++; $display("FAIL exp_start_ignored: got ers=%0d exp=%0d fd=%0d expected 5/10/1", n_erase, n_expose, n_fd); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exp_idle: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    continuous = 1'b1; expose_len = E10; out_ready = 1'b1;
    kick();
    mon(3, 2000, 1'b0);
    continuous = 1'b0;
    checks++; if (n_fd != 3) begin errors++; $display("FAIL cont_frames: got %0d expected 3", n_fd); end
    if (t_fd.size() == 3) begin
      checks++; if (t_fd[1]-t_fd[0] != PER || t_fd[2]-t_fd[1] != PER) begin errors++; $display("FAIL cont_period: got %0d,%0d expected %0d", t_fd[1]-t_fd[0], t_fd[2]-t_fd[1], PER); end
    end
    checks++; if (busy_low != 0 || n_erase != 15) begin errors++; $display("FAIL cont_busy: got low=%0d ers=%0d expected 0/15", busy_low, n_erase); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop: got busy=%0b expected 0", busy); end
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (rd.out_valid !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    ok = (rd.out_valid === 1'b1);
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    logic [15:0] d0;
    out_ready = 1'b0; expose_len = 16'd2;
    kick();
    wait_valid(ok);
    if (HDR != 0 && ok) begin
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
      wait_valid(ok);
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid: got out_valid=%0b expected 1", rd.out_valid); end
    d0 = rd.out_data;
    checks++; if (d0 !== 16'h1122 || row_sel !== 2'd0) begin errors++; $display("FAIL bp_row0: got %0h sel=%0d expected 1122 sel=0", d0, row_sel); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd.out_data !== d0 || rd.out_valid !== 1'b1 || row_sel !== 2'd0 || {erase, expose, convert, frame_done} !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (rd.out_valid !== 1'b0 || row_sel !== 2'd1) begin errors++; $display("FAIL bp_accept: got v=%0b sel=%0d expected 0/1", rd.out_valid, row_sel); end
    mon(1, 50, 1'b0);
    checks++; if (n_fd != 1 || bdata.size() != 1 || bdata[0] !== 16'h3344) begin errors++; $display("FAIL bp_finish: got fd=%0d beats=%0d expected 1/1 of 3344", n_fd, bdata.size()); end
  endtask

`ifdef SEQ_FRAME_COUNT_EN
  task automatic test_frame_count();
    @(negedge clk); reset = 1'b0; @(negedge clk); reset = 1'b1;
    out_ready = 1'b1; expose_len = 16'd1;
    kick(); mon(1, 600, 1'b0);
    checks++; if (bdata.size() < 1 || bdata[0] !== 16'h0000) begin errors++; $display("FAIL fc_hdr0: got %0h expected 0000", bdata[0]); end
    kick(); mon(1, 600, 1'b0);
    checks++; if (bdata.size() < 1 || bdata[0] !== 16'h0001) begin errors++; $display("FAIL fc_hdr1: got %0h expected 0001", bdata[0]); end
    @(negedge clk);
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL fc_cnt: got %0d expected 2", frame_cnt); end
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    kick(); mon(1, 600, 1'b0);
    @(negedge clk);
    checks++; if (bdata.size() < 1 || bdata[0] !== 16'h00FF || frame_cnt !== 16'h0000) begin errors++; $display("FAIL fc_wrap: got hdr=%0h cnt=%0h expected 00ff/0000", bdata[0], frame_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_exposure_edge();
    test_back_to_back();
    test_backpressure();
`ifdef SEQ_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
